arbitrating_multiplexor: RTL and testbench
==========================================

Name: arbitrating_multiplexor

Overview:
- N-to-1 packet multiplexor: merges N valid/ready input channels onto one output channel. It is the gather-side counterpart of the address-driven demultiplexor.
- Round-robin arbitration between inputs; a grant is held for a whole packet (in_last marks the final beat).
- The winning source index goes out on out_address, so a downstream demultiplexor can route responses back by that address.
- Single registered output stage; one beat per cycle at full throughput.

Parameters:
ADDRESS_WIDTH, 2, source index width; N = 1<<ADDRESS_WIDTH input channels
DATA_WIDTH, 8, payload bits per beat

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  N  per-source beat valid
in_ready  output  N  per-source beat accepted (combinational)
in_data  input  N*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_last  input  N  per-source final beat of packet
out_valid  output  1  registered beat valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH  registered payload
out_last  output  1  registered last flag
out_address  output  ADDRESS_WIDTH  source index of current out beat

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: out_valid=0, out_data=0, out_last=0, out_address=0, rr pointer=0, state=IDLE.
- Transfer rules:
  - A transfer occurs on an input when in_valid[i] & in_ready[i].
  - A transfer occurs on the output when out_valid & out_ready.
- can_load = !out_valid | out_ready, so a full output register is drained and reloaded in the same cycle (no bubble).
- At most one in_ready bit is high in any cycle. in_ready never depends on out_valid alone while out_ready=1.
- State IDLE:
  - winner = first i with in_valid[i], searching from pointer upward and wrapping N-1 -> 0.
  - in_ready[winner] = can_load; no grant when no in_valid is set.
  - On accept with in_last=1: stay IDLE; pointer <= winner+1 (mod N).
  - On accept with in_last=0: go LOCKED, owner <= winner.
- State LOCKED:
  - in_ready[owner] = in_valid[owner] & can_load. All other sources are held off even if owner's in_valid drops.
  - On accept with in_last=1: go IDLE; pointer <= owner+1 (mod N).
- Output load: on input accept, the register captures in_data slice, in_last and source index next edge. Latency is 1 cycle from accept to out_valid.
- If can_load & no accept: out_valid <= 0. If !can_load: all out_* hold stable.
- A single requester issuing 1-beat packets is granted every cycle; the pointer still advances.
- Reset mid-packet returns to IDLE and drops the registered beat (out_valid=0). The partial packet is lost; no recovery.

Decomposition:
- Package arbitrating_multiplexor_pkg holds:
  - state enum (IDLE=0, LOCKED=1)
  - function/localparam for N from ADDRESS_WIDTH
- Sub-module rr_priority_picker (combinational):
  - inputs: request vector, pointer
  - outputs: one-hot grant, binary winner index, any_grant
  - implemented as rotate, find-first, rotate back.
- Top module holds FSM, owner/pointer regs, output register.

Test Plan:
- Reset then in_valid=4'b1111, all in_last=1, out_ready=1 -> out_address sequence 0,1,2,3,0; one beat per cycle; out_valid first high 1 cycle after first accept.
- Source 2 sends 3-beat packet (data A,B,C, last on C) while source 0 valid throughout -> out beats A,B,C from address 2 contiguous, then source 3 idle so source 0 next; in_ready[0]=0 during packet.
- out_ready=0 for 4 cycles with out_valid=1, data 0x5A -> out_data/out_address/out_last stable; all in_ready=0; resumes with no beat lost or duplicated.
- Source 1 in LOCKED drops in_valid for 2 cycles, source 3 valid -> no output beats, in_ready[3]=0; source 1 resumes and finishes; then source 3 granted.
- Pointer at 3, requests 4'b1001 -> grant 3, then 0 (wrap); ADDRESS_WIDTH=1 build repeats with 2 sources.
- rst_n low mid-packet (LOCKED, out_valid=1) -> out_valid=0 immediately (async); after release, IDLE with pointer 0: requests 4'b0110 grant 1 first.

Source files
------------

// File: rtl/arbitrating_multiplexor_pkg.sv
// Shared types and sizing helpers for the arbitrating multiplexor.
// The source count is always a power of two derived from the address width.
package arbitrating_multiplexor_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int num_sources(input int address_width);
    return 1 << address_width;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the search starts at the pointer and wraps.
// The request vector is rotated, the first set bit is found, and the offset is rotated back.
module rr_priority_picker
  import arbitrating_multiplexor_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 2,
  localparam int N = num_sources(ADDRESS_WIDTH)
) (
  input  logic [N-1:0]             request,
  input  logic [ADDRESS_WIDTH-1:0] pointer,
  output logic [N-1:0]             grant,
  output logic [ADDRESS_WIDTH-1:0] winner,
  output logic                     any_grant
);

  logic [N-1:0]             rotated;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     found;

  // Rotation index arithmetic wraps naturally at ADDRESS_WIDTH bits.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < N; i++) begin
      rotated[i] = request[ADDRESS_WIDTH'(i) + pointer];
    end
  end

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rotated[i] && !found) begin
        offset = ADDRESS_WIDTH'(i);
        found  = 1'b1;
      end
    end
  end

  assign any_grant = |request;
  assign winner    = pointer + offset;
  assign grant     = any_grant ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

endmodule

// File: rtl/arbitrating_multiplexor.sv
// N-to-1 packet multiplexor with round-robin arbitration held for whole packets.
// The winning source index travels with each beat on out_address.
module arbitrating_multiplexor
  import arbitrating_multiplexor_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 8,
  localparam int N = num_sources(ADDRESS_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            in_valid,
  output logic [N-1:0]            in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic [N-1:0]            in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [ADDRESS_WIDTH-1:0] out_address
);

  // Handshake: a beat moves on a channel in any cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and in_ready is combinational.

  state_t                   state, next_state;
  logic [ADDRESS_WIDTH-1:0] pointer, owner, winner, sel;
  logic [N-1:0]             grant;
  logic                     any_grant;
  logic                     can_load, accept, sel_last;
  logic [DATA_WIDTH-1:0]    sel_data;

  rr_priority_picker #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_picker (
    .request   (in_valid),
    .pointer   (pointer),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign can_load = !out_valid || out_ready;
  assign sel      = (state == IDLE) ? winner : owner;
  assign sel_last = in_last[sel];
  assign sel_data = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign accept   = |(in_valid & in_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !sel_last) next_state = LOCKED;
      LOCKED:  if (accept && sel_last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant outputs; a locked owner blocks everyone else even while it idles.
  always_comb begin
    in_ready = '0;
    case (state)
      IDLE:    in_ready = any_grant ? (grant & {N{can_load}}) : '0;
      LOCKED:  in_ready[owner] = in_valid[owner] & can_load;
      default: in_ready = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer <= '0;
      owner   <= '0;
    end else begin
      if (state == IDLE && accept) owner <= winner;
      if (accept && sel_last)      pointer <= sel + ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_address <= '0;
    end else if (can_load) begin
      out_valid <= accept;
      if (accept) begin
        out_data    <= sel_data;
        out_last    <= sel_last;
        out_address <= sel;
      end
    end
  end

endmodule

// File: tb/tb_arbitrating_multiplexor.sv
// Directed bench: a vector table for the 4-source build plus hand sequences
// for asynchronous reset mid-packet and a 2-source build.
module tb_arbitrating_multiplexor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [1:0]  out_address;

  logic [1:0]  b_in_valid, b_in_ready, b_in_last;
  logic [15:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_out_data;
  logic        b_out_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitrating_multiplexor #(.ADDRESS_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_address(out_address)
  );

  arbitrating_multiplexor #(.ADDRESS_WIDTH(1), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .out_address(b_out_address)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [7:0]  exp_odata;
    logic        exp_olast;
    logic [1:0]  exp_oaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                     input logic ordy, input logic [3:0] er, input logic eov,
                     input logic [7:0] eod, input logic eol, input logic [1:0] eoa);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.oready = ordy; x.exp_ready = er;
    x.exp_ovalid = eov; x.exp_odata = eod; x.exp_olast = eol; x.exp_oaddr = eoa;
    vecs.push_back(x);
  endtask

  // Drive one cycle, check combinational ready before the edge, registered out after it.
  task automatic apply(input vec_t x, input string tag);
    in_valid = x.valid; in_last = x.last; in_data = x.data; out_ready = x.oready;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(x.exp_ready));
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(x.exp_ovalid));
    if (x.exp_ovalid) begin
      chk({tag, " out_data"}, 32'(out_data), 32'(x.exp_odata));
      chk({tag, " out_last"}, 32'(out_last), 32'(x.exp_olast));
      chk({tag, " out_address"}, 32'(out_address), 32'(x.exp_oaddr));
    end
  endtask

  task automatic b_step(input logic [1:0] exp_ready, input logic [7:0] exp_data,
                        input logic exp_addr, input string tag);
    b_in_valid = 2'b11; b_in_last = 2'b11; b_in_data = 16'hB1B0; b_out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(b_in_ready), 32'(exp_ready));
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 32'(b_out_valid), 32'(1'b1));
    chk({tag, " out_data"}, 32'(b_out_data), 32'(exp_data));
    chk({tag, " out_address"}, 32'(b_out_address), 32'(exp_addr));
  endtask

  initial begin
    vec_t x;
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_out_ready = 1'b0;

    // All four sources with single-beat packets: strict rotation 0,1,2,3,0.
    add(4'hF, 4'hF, 32'h33221100, 1, 4'b0001, 1, 8'h00, 1, 0);
    add(4'hF, 4'hF, 32'h33221100, 1, 4'b0010, 1, 8'h11, 1, 1);
    add(4'hF, 4'hF, 32'h33221100, 1, 4'b0100, 1, 8'h22, 1, 2);
    add(4'hF, 4'hF, 32'h33221100, 1, 4'b1000, 1, 8'h33, 1, 3);
    add(4'hF, 4'hF, 32'h33221100, 1, 4'b0001, 1, 8'h00, 1, 0);
    // Back-pressure: 0x5A from source 1 held for four cycles, then drained once.
    add(4'hF, 4'hF, 32'h5A5A5A5A, 1, 4'b0010, 1, 8'h5A, 1, 1);
    for (int i = 0; i < 4; i++) add(4'hF, 4'hF, 32'h5A5A5A5A, 0, 4'b0000, 1, 8'h5A, 1, 1);
    add(4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    // Source 2 three-beat packet while source 0 keeps requesting.
    add(4'h5, 4'h1, 32'h00AA000F, 1, 4'b0100, 1, 8'hAA, 0, 2);
    add(4'h5, 4'h1, 32'h00BB000F, 1, 4'b0100, 1, 8'hBB, 0, 2);
    add(4'h5, 4'h5, 32'h00CC000F, 1, 4'b0100, 1, 8'hCC, 1, 2);
    add(4'h1, 4'h1, 32'h0000000F, 1, 4'b0001, 1, 8'h0F, 1, 0);
    // Locked source 1 pauses two cycles; source 3 must wait.
    add(4'hA, 4'h8, 32'h3C004100, 1, 4'b0010, 1, 8'h41, 0, 1);
    add(4'h8, 4'h8, 32'h3C000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(4'h8, 4'h8, 32'h3C000000, 1, 4'b0000, 0, 8'h00, 0, 0);
    add(4'hA, 4'hA, 32'h3C004200, 1, 4'b0010, 1, 8'h42, 1, 1);
    add(4'h8, 4'h8, 32'h3C000000, 1, 4'b1000, 1, 8'h3C, 1, 3);
    // Move pointer to 3, then requests 1001 wrap 3 -> 0.
    add(4'h4, 4'h4, 32'h00250000, 1, 4'b0100, 1, 8'h25, 1, 2);
    add(4'h9, 4'h9, 32'h39000009, 1, 4'b1000, 1, 8'h39, 1, 3);
    add(4'h9, 4'h9, 32'h39000009, 1, 4'b0001, 1, 8'h09, 1, 0);
    // Lone requester is granted every cycle.
    add(4'h1, 4'h1, 32'h00000009, 1, 4'b0001, 1, 8'h09, 1, 0);
    add(4'h1, 4'h1, 32'h00000009, 1, 4'b0001, 1, 8'h09, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset out_address", 32'(out_address), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset mid-packet: source 0 starts a packet, reset drops it asynchronously.
    x = '{valid: 4'h1, last: 4'h0, data: 32'h00000077, oready: 1, exp_ready: 4'b0001,
          exp_ovalid: 1, exp_odata: 8'h77, exp_olast: 0, exp_oaddr: 0};
    apply(x, "midpkt");
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset out_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    x = '{valid: 4'h6, last: 4'h6, data: 32'h00221100, oready: 1, exp_ready: 4'b0010,
          exp_ovalid: 1, exp_odata: 8'h11, exp_olast: 1, exp_oaddr: 1};
    apply(x, "post_reset");
    in_valid = '0;

    // Two-source build: rotation 0,1,0.
    b_step(2'b01, 8'hB0, 1'b0, "b0");
    b_step(2'b10, 8'hB1, 1'b1, "b1");
    b_step(2'b01, 8'hB0, 1'b0, "b2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
